// File: rtl/display_scan_controller_if.sv
// Display scan bus: BCD digit load side plus decoder nibble / digit-enable side.
interface display_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic                    lz_blank;
  logic                    A;
  logic                    B;
  logic                    C;
  logic                    D;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    blank;
  logic                    frame_done;

  modport master (
    output digits_in, load, lz_blank,
    input  A, B, C, D, dig_en, blank, frame_done
  );

  modport slave (
    input  digits_in, load, lz_blank,
    output A, B, C, D, dig_en, blank, frame_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan controller: one BCD nibble per slot, blanking gap before each enable.
// All outputs registered (aligned with the slot counter); free-running, no backpressure.
module display_scan_controller #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 1000,
  parameter int BLANK_CYCLES  = 8,
  parameter int EN_ACTIVE_LOW = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  display_scan_controller_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF =
    (EN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t                      state_q, state_nxt;
  logic [CW-1:0]               cnt_q, cnt_nxt;
  logic [IW-1:0]               idx_q, idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_nxt;
  logic [NUM_DIGITS-1:0][3:0]  active_q, active_nxt;
  logic [NUM_DIGITS-1:0][3:0]  digits_w;
  logic                        pending_q, pending_nxt;
  logic                        supp_q, supp_nxt;
  logic [3:0]                  abcd_q, abcd_nxt;
  logic [NUM_DIGITS-1:0]       dig_en_q, dig_en_nxt;
  logic                        blank_q, blank_nxt;
  logic                        frame_done_q, frame_done_nxt;
  logic                        slot_end, frame_end, show, zacc;
  logic [NUM_DIGITS-1:0]       zero_above, onehot;

  assign digits_w = bus.digits_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      supp_q       <= 1'b0;
      abcd_q       <= 4'd0;
      dig_en_q     <= EN_OFF;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      idx_q        <= idx_nxt;
      shadow_q     <= shadow_nxt;
      active_q     <= active_nxt;
      pending_q    <= pending_nxt;
      supp_q       <= supp_nxt;
      abcd_q       <= abcd_nxt;
      dig_en_q     <= dig_en_nxt;
      blank_q      <= blank_nxt;
      frame_done_q <= frame_done_nxt;
    end
  end

  always_comb begin
    slot_end    = (cnt_q == CNT_MAX);
    frame_end   = slot_end && (idx_q == IDX_MAX);
    cnt_nxt     = slot_end ? '0 : cnt_q + CW'(1);
    idx_nxt     = idx_q;
    if (slot_end) begin
      idx_nxt = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end

    shadow_nxt  = bus.load ? digits_w : shadow_q;
    pending_nxt = bus.load ? 1'b1 : pending_q;
    active_nxt  = active_q;
    // A load landing on the wrap cycle bypasses the shadow so it shows without a frame of delay.
    if (frame_end) begin
      if (bus.load) begin
        active_nxt = digits_w;
      end else if (pending_q) begin
        active_nxt = shadow_q;
      end
      pending_nxt = 1'b0;
    end

    state_nxt = (cnt_nxt < CNT_SHOW) ? S_BLANK : S_SHOW;

    // zero_above[i]: digit i and every more-significant digit are zero.
    zacc       = 1'b1;
    zero_above = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc          = zacc & (active_nxt[i] == 4'd0);
      zero_above[i] = zacc;
    end

    supp_nxt = supp_q;
    if (slot_end) begin
      supp_nxt = bus.lz_blank && (idx_nxt != '0) && zero_above[idx_nxt];
    end

    onehot          = '0;
    onehot[idx_nxt] = 1'b1;
    show            = (state_nxt == S_SHOW) && !supp_nxt;
    dig_en_nxt      = show ? ((EN_ACTIVE_LOW != 0) ? ~onehot : onehot) : EN_OFF;
    blank_nxt       = !show;
    abcd_nxt        = active_nxt[idx_nxt];
    frame_done_nxt  = frame_end;
  end

  assign bus.A          = abcd_q[3];
  assign bus.B          = abcd_q[2];
  assign bus.C          = abcd_q[1];
  assign bus.D          = abcd_q[0];
  assign bus.dig_en     = dig_en_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller (4 digits, 16-cycle slots, 2-cycle blanking).
module tb_display_scan_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cur;

  typedef struct packed {
    logic [1:0] slot;
    logic [3:0] nib;
    logic       en;
  } exp_t;

  exp_t sb[$];

  display_scan_controller_if #(.NUM_DIGITS(4)) bus ();

  display_scan_controller #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (16),
    .BLANK_CYCLES (2),
    .EN_ACTIVE_LOW(0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_slot(input logic [1:0] s, input logic [3:0] n, input logic e);
    exp_t r;
    r.slot = s;
    r.nib  = n;
    r.en   = e;
    sb.push_back(r);
  endtask

  // Hand-computed nibble for slots 0..3 and per-slot enable mask (bit i = slot i).
  task automatic push_frame(input logic [3:0] n0, input logic [3:0] n1,
                            input logic [3:0] n2, input logic [3:0] n3,
                            input logic [3:0] en);
    push_slot(2'd0, n0, en[0]);
    push_slot(2'd1, n1, en[1]);
    push_slot(2'd2, n2, en[2]);
    push_slot(2'd3, n3, en[3]);
  endtask

  task automatic goto(input int k);
    if (k > cur) begin
      repeat (k - cur) @(posedge clk);
      #2;
      cur = k;
    end
  endtask

  task automatic load_pulse(input logic [15:0] v);
    bus.digits_in = v;
    bus.load      = 1'b1;
    goto(cur + 1);
    bus.load      = 1'b0;
  endtask

  function automatic logic [3:0] abcd();
    return {bus.A, bus.B, bus.C, bus.D};
  endfunction

  // Monitor: tracks its own cycle count since reset release and checks each slot.
  initial begin
    int   cyc;
    int   phase;
    exp_t rec;
    logic have;
    cyc  = 0;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc  = 0;
        have = 1'b0;
      end else begin
        phase = cyc % 16;
        check("frame_done", {15'd0, bus.frame_done}, {15'd0, (cyc % 64 == 0) && (cyc != 0)});
        if (phase < 2 && sb.size() > 0) begin
          check("gap_nibble", {12'd0, abcd()}, {12'd0, sb[0].nib});
          check("gap_dig_en", {12'd0, bus.dig_en}, 16'd0);
          check("gap_blank", {15'd0, bus.blank}, 16'd1);
        end
        if (phase == 2 && sb.size() > 0) begin
          rec  = sb.pop_front();
          have = 1'b1;
          check("slot_nibble", {12'd0, abcd()}, {12'd0, rec.nib});
          check("slot_dig_en", {12'd0, bus.dig_en}, rec.en ? (16'd1 << rec.slot) : 16'd0);
          check("slot_blank", {15'd0, bus.blank}, {15'd0, !rec.en});
        end
        if (phase == 15 && have) begin
          check("end_nibble", {12'd0, abcd()}, {12'd0, rec.nib});
          check("end_dig_en", {12'd0, bus.dig_en}, rec.en ? (16'd1 << rec.slot) : 16'd0);
        end
        cyc++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    cur           = 0;
    rst_n         = 1'b0;
    bus.digits_in = 16'h0000;
    bus.load      = 1'b0;
    bus.lz_blank  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dig_en", {12'd0, bus.dig_en}, 16'd0);
    check("rst_blank", {15'd0, bus.blank}, 16'd1);
    check("rst_abcd", {12'd0, abcd()}, 16'd0);
    check("rst_frame_done", {15'd0, bus.frame_done}, 16'd0);

    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b1111);
    rst_n = 1'b1;
    cur   = 0;

    goto(5);
    load_pulse(16'h1234);
    push_frame(4'h4, 4'h3, 4'h2, 4'h1, 4'b1111);

    // Mid-frame load in slot1 of frame 1: takes effect in frame 2 only.
    goto(84);
    load_pulse(16'h9876);
    push_frame(4'h6, 4'h7, 4'h8, 4'h9, 4'b1111);

    goto(140);
    bus.lz_blank = 1'b1;
    load_pulse(16'h0050);
    push_frame(4'h0, 4'h5, 4'h0, 4'h0, 4'b0011);

    goto(200);
    load_pulse(16'h0000);
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b0001);

    // Load on the wrap cycle (last cycle of frame 4).
    goto(319);
    bus.lz_blank = 1'b0;
    load_pulse(16'hABCD);
    push_frame(4'hD, 4'hC, 4'hB, 4'hA, 4'b1111);
    push_slot(2'd0, 4'hD, 1'b1);
    push_slot(2'd1, 4'hC, 1'b1);
    push_slot(2'd2, 4'hB, 1'b1);

    // Frame 6 slot2, counter 9.
    goto(425);
    rst_n = 1'b0;
    #1;
    check("midrst_dig_en", {12'd0, bus.dig_en}, 16'd0);
    check("midrst_blank", {15'd0, bus.blank}, 16'd1);
    check("midrst_abcd", {12'd0, abcd()}, 16'd0);
    check("midrst_frame_done", {15'd0, bus.frame_done}, 16'd0);
    check("midrst_sb_empty", 16'(sb.size()), 16'd0);

    repeat (2) @(posedge clk);
    #2;
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b1111);
    rst_n = 1'b1;
    cur   = 0;
    goto(70);
    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
